// File: rtl/acc_seq_pkg.sv
// Shared definitions for the accumulator tile sequencer: tile FSM encoding,
// default data width and saturation limits at that width.
package acc_seq_pkg;

    localparam int ACC_DATA_W = 32;

    localparam logic [1:0] ACC_ST_IDLE_ENC  = 2'd0;
    localparam logic [1:0] ACC_ST_FILL_ENC  = 2'd1;
    localparam logic [1:0] ACC_ST_DRAIN_ENC = 2'd2;
    localparam logic [1:0] ACC_ST_DONE_ENC  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = ACC_ST_IDLE_ENC,
        ST_FILL  = ACC_ST_FILL_ENC,
        ST_DRAIN = ACC_ST_DRAIN_ENC,
        ST_DONE  = ACC_ST_DONE_ENC
    } acc_state_e;

    localparam logic [ACC_DATA_W-1:0] ACC_SAT_MAX = {1'b0, {(ACC_DATA_W-1){1'b1}}};
    localparam logic [ACC_DATA_W-1:0] ACC_SAT_MIN = {1'b1, {(ACC_DATA_W-1){1'b0}}};

endpackage

// File: rtl/acc_sat_add.sv
// Signed two's-complement saturating adder; ovf flags any clamp.
// Instantiated by acc_tile_sequencer only when ACC_SEQ_ACCUM_EN is defined.
module acc_sat_add
    import acc_seq_pkg::*;
#(
    parameter int DATA_W = ACC_DATA_W
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] sum,
    output logic              ovf
);

    localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    logic [DATA_W:0] sum_wide;

    // One guard bit: the true sign is sum_wide[DATA_W], overflow when it disagrees with the MSB.
    always_comb begin
        sum_wide = {a[DATA_W-1], a} + {b[DATA_W-1], b};
        ovf      = sum_wide[DATA_W] != sum_wide[DATA_W-1];
        if (!ovf) begin
            sum = sum_wide[DATA_W-1:0];
        end else if (sum_wide[DATA_W]) begin
            sum = SAT_MIN;
        end else begin
            sum = SAT_MAX;
        end
    end

endmodule

// File: rtl/acc_tile_sequencer.sv
// Accumulator buffer sequencer for one output tile: FILL from the array, optional DRAIN.
// Optional feature macro: ACC_SEQ_ACCUM_EN (saturating accumulate into entries, sticky overflow).
module acc_tile_sequencer
    import acc_seq_pkg::*;
#(
    parameter int DATA_W = ACC_DATA_W,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   tile_len,
    input  logic              drain_en,
    input  logic              acc_mode,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic              overflow
);

    localparam logic [ADDR_W:0] DEPTH_LEN = DEPTH[ADDR_W:0];

    acc_state_e          state_q, state_d;
    logic [ADDR_W:0]     len_q, len_d;
    logic                drain_en_q, drain_en_d;
    logic                acc_mode_q, acc_mode_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [DATA_W-1:0]   mem_d [DEPTH];
    logic                overflow_q, overflow_d;

    logic                len_ok;
    logic [ADDR_W:0]     len_m1;
    logic                last_wr;
    logic                last_rd;
    logic [DATA_W-1:0]   wr_data;
    logic                wr_ovf;

`ifdef ACC_SEQ_ACCUM_EN
    logic [DATA_W-1:0]   sat_sum;
    logic                sat_ovf;

    acc_sat_add #(.DATA_W(DATA_W)) u_sat_add (
        .a   (mem_q[wr_ptr_q]),
        .b   (in_data),
        .sum (sat_sum),
        .ovf (sat_ovf)
    );

    assign wr_data = acc_mode_q ? sat_sum : in_data;
    assign wr_ovf  = acc_mode_q & sat_ovf;
`else
    logic unused_acc_mode;

    assign unused_acc_mode = acc_mode_q;
    assign wr_data         = in_data;
    assign wr_ovf          = 1'b0;
`endif

    assign len_ok  = (tile_len != '0) && (tile_len <= DEPTH_LEN);
    assign len_m1  = len_q - 1'b1;
    assign last_wr = ({1'b0, wr_ptr_q} == len_m1);
    assign last_rd = ({1'b0, rd_ptr_q} == len_m1);

    // Handshakes are valid/ready: a beat transfers on the rising edge where both are high.
    // in_ready and out_valid are pure state decodes, so they never depend on the partner's signal.
    assign in_ready  = (state_q == ST_FILL);
    assign out_valid = (state_q == ST_DRAIN);
    assign out_data  = mem_q[rd_ptr_q];
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign overflow  = overflow_q;

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        drain_en_d = drain_en_q;
        acc_mode_d = acc_mode_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        mem_d      = mem_q;
        overflow_d = overflow_q;

        case (state_q)
            ST_IDLE: begin
                if (start && len_ok) begin
                    len_d      = tile_len;
                    drain_en_d = drain_en;
                    acc_mode_d = acc_mode;
                    wr_ptr_d   = '0;
                    rd_ptr_d   = '0;
                    overflow_d = 1'b0;
                    state_d    = ST_FILL;
                end
            end
            ST_FILL: begin
                if (in_valid) begin
                    mem_d[wr_ptr_q] = wr_data;
                    overflow_d      = overflow_q | wr_ovf;
                    wr_ptr_d        = wr_ptr_q + 1'b1;
                    if (last_wr) begin
                        rd_ptr_d = '0;
                        state_d  = drain_en_q ? ST_DRAIN : ST_DONE;
                    end
                end
            end
            ST_DRAIN: begin
                if (out_ready) begin
                    rd_ptr_d = rd_ptr_q + 1'b1;
                    if (last_rd) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            drain_en_q <= 1'b0;
            acc_mode_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            drain_en_q <= drain_en_d;
            acc_mode_q <= acc_mode_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
            mem_q      <= mem_d;
        end
    end

endmodule

// File: tb/tb_acc_tile_sequencer.sv
// Directed bench for acc_tile_sequencer: a per-cycle vector table plus hand sequences
// for reset, accumulate passes and saturation (expectations follow ACC_SEQ_ACCUM_EN).
module tb_acc_tile_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  tile_len;
    logic        drain_en;
    logic        acc_mode;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;
    logic        busy;
    logic        done;
    logic        overflow;

    int n_vec = 0;
    int n_err = 0;

    acc_tile_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .tile_len  (tile_len),
        .drain_en  (drain_en),
        .acc_mode  (acc_mode),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running, required finished");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        start;
        logic [2:0]  len;
        logic        drain;
        logic        iv;
        logic [31:0] id;
        logic        ordy;
        logic        e_ir;
        logic        e_ov;
        logic        e_busy;
        logic        e_done;
        logic        chk_d;
        logic [31:0] e_d;
    } vec_t;

    vec_t vecs [23];

    function automatic vec_t mk(input logic st, input logic [2:0] ln, input logic dr,
                                input logic iv, input logic [31:0] id, input logic ordy,
                                input logic e_ir, input logic e_ov, input logic e_busy,
                                input logic e_done, input logic chk_d, input logic [31:0] e_d);
        vec_t v;
        v.start = st;   v.len = ln;     v.drain = dr;
        v.iv = iv;      v.id = id;      v.ordy = ordy;
        v.e_ir = e_ir;  v.e_ov = e_ov;  v.e_busy = e_busy;
        v.e_done = e_done; v.chk_d = chk_d; v.e_d = e_d;
        return v;
    endfunction

    // scoreboard helpers
    task automatic check1(input string name, input logic got, input logic exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b", name, got, exp);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
        end
    endtask

    // driver tasks: all called and returning on a negedge
    task automatic do_start(input logic [2:0] len, input logic dr, input logic acc);
        start = 1'b1; tile_len = len; drain_en = dr; acc_mode = acc;
        @(negedge clk);
        start = 1'b0;
        check1("start_accepted", busy, 1'b1);
    endtask

    task automatic push(input logic [31:0] d);
        int t;
        t = 0;
        in_valid = 1'b1; in_data = d;
        while (!in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        check1("push_ready", in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic pop(output logic [31:0] d);
        int t;
        t = 0;
        out_ready = 1'b1;
        while (!out_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        check1("pop_valid", out_valid, 1'b1);
        d = out_data;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (!done && t < 20) begin
            @(negedge clk);
            t++;
        end
        check1("done_seen", done, 1'b1);
        @(negedge clk);
        check1("done_one_cycle", done, 1'b0);
        check1("idle_after_done", busy, 1'b0);
    endtask

    logic [31:0] exp_q [$];
    logic [31:0] got_d;
    logic [31:0] exp_a, exp_b, exp_sat;
    logic        exp_ovf;

    initial begin
        //            st ln dr iv id  ordy ir ov by dn chk data
        vecs[0]  = mk(0, 0, 0, 0, 0,   0,  0, 0, 0, 0, 1, 0);
        vecs[1]  = mk(1, 0, 1, 0, 0,   0,  0, 0, 0, 0, 1, 0);
        vecs[2]  = mk(1, 5, 1, 0, 0,   0,  0, 0, 0, 0, 1, 0);
        vecs[3]  = mk(0, 0, 0, 0, 0,   0,  0, 0, 0, 0, 1, 0);
        vecs[4]  = mk(1, 4, 1, 0, 0,   0,  0, 0, 0, 0, 1, 0);
        vecs[5]  = mk(0, 0, 0, 1, 10,  0,  1, 0, 1, 0, 1, 0);
        vecs[6]  = mk(1, 2, 0, 1, 20,  0,  1, 0, 1, 0, 1, 10);
        vecs[7]  = mk(0, 0, 0, 0, 0,   0,  1, 0, 1, 0, 1, 10);
        vecs[8]  = mk(0, 0, 0, 1, 30,  0,  1, 0, 1, 0, 1, 10);
        vecs[9]  = mk(0, 0, 0, 1, 40,  0,  1, 0, 1, 0, 1, 10);
        vecs[10] = mk(0, 0, 0, 1, 99,  1,  0, 1, 1, 0, 1, 10);
        vecs[11] = mk(0, 0, 0, 0, 0,   0,  0, 1, 1, 0, 1, 20);
        vecs[12] = mk(0, 0, 0, 0, 0,   0,  0, 1, 1, 0, 1, 20);
        vecs[13] = mk(0, 0, 0, 0, 0,   0,  0, 1, 1, 0, 1, 20);
        vecs[14] = mk(0, 0, 0, 0, 0,   1,  0, 1, 1, 0, 1, 20);
        vecs[15] = mk(0, 0, 0, 0, 0,   1,  0, 1, 1, 0, 1, 30);
        vecs[16] = mk(0, 0, 0, 0, 0,   1,  0, 1, 1, 0, 1, 40);
        vecs[17] = mk(0, 0, 0, 0, 0,   0,  0, 0, 1, 1, 0, 0);
        vecs[18] = mk(1, 2, 0, 0, 0,   0,  0, 0, 0, 0, 0, 0);
        vecs[19] = mk(0, 0, 0, 1, 5,   0,  1, 0, 1, 0, 0, 0);
        vecs[20] = mk(0, 0, 0, 1, 7,   0,  1, 0, 1, 0, 0, 0);
        vecs[21] = mk(0, 0, 0, 0, 0,   0,  0, 0, 1, 1, 0, 0);
        vecs[22] = mk(0, 0, 0, 1, 77,  0,  0, 0, 0, 0, 0, 0);

        reset = 1'b1; start = 1'b0; tile_len = '0; drain_en = 1'b0; acc_mode = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check1("rst_in_ready", in_ready, 1'b0);
        check1("rst_out_valid", out_valid, 1'b0);
        check32("rst_out_data", out_data, 32'd0);
        check1("rst_busy", busy, 1'b0);
        check1("rst_done", done, 1'b0);
        check1("rst_overflow", overflow, 1'b0);
        reset = 1'b0;

        // per-cycle table: outputs are state decodes, checked before the edge that consumes the row
        for (int i = 0; i < 23; i++) begin
            start = vecs[i].start; tile_len = vecs[i].len; drain_en = vecs[i].drain;
            acc_mode = 1'b0; in_valid = vecs[i].iv; in_data = vecs[i].id;
            out_ready = vecs[i].ordy;
            check1($sformatf("v%0d_in_ready", i), in_ready, vecs[i].e_ir);
            check1($sformatf("v%0d_out_valid", i), out_valid, vecs[i].e_ov);
            check1($sformatf("v%0d_busy", i), busy, vecs[i].e_busy);
            check1($sformatf("v%0d_done", i), done, vecs[i].e_done);
            if (vecs[i].chk_d) begin
                check32($sformatf("v%0d_out_data", i), out_data, vecs[i].e_d);
            end
            @(negedge clk);
        end
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        check1("idle_ignores_in_valid", busy, 1'b0);

        // short tile touched entries 0..1 only
        exp_q = '{32'd5, 32'd7, 32'd30, 32'd40};
        for (int i = 0; i < 4; i++) begin
            check32($sformatf("entry%0d_after_len2", i), dut.mem_q[i], exp_q[i]);
        end

        // two-pass accumulate (plain overwrite when the feature is compiled out)
`ifdef ACC_SEQ_ACCUM_EN
        exp_a = 32'd6;  exp_b = 32'd9;
`else
        exp_a = 32'd1;  exp_b = 32'd2;
`endif
        do_start(3'd2, 1'b0, 1'b0);
        push(32'd5);
        push(32'd7);
        wait_done();
        do_start(3'd2, 1'b1, 1'b1);
        push(32'd1);
        push(32'd2);
        pop(got_d);
        check32("accum_out0", got_d, exp_a);
        pop(got_d);
        check32("accum_out1", got_d, exp_b);
        wait_done();
        check1("accum_no_overflow", overflow, 1'b0);

        // saturation at the positive limit, sticky until the next accepted start
`ifdef ACC_SEQ_ACCUM_EN
        exp_sat = 32'h7FFF_FFFF; exp_ovf = 1'b1;
`else
        exp_sat = 32'h0000_0020; exp_ovf = 1'b0;
`endif
        do_start(3'd1, 1'b0, 1'b0);
        push(32'h7FFF_FFF0);
        wait_done();
        do_start(3'd1, 1'b1, 1'b1);
        push(32'h0000_0020);
        pop(got_d);
        check32("sat_out", got_d, exp_sat);
        wait_done();
        check1("sat_overflow_sticky", overflow, exp_ovf);
        @(negedge clk);
        check1("sat_overflow_held_idle", overflow, exp_ovf);
        do_start(3'd1, 1'b0, 1'b0);
        check1("overflow_cleared_on_start", overflow, 1'b0);
        push(32'd0);
        wait_done();

        // reset in the middle of FILL after two writes
        do_start(3'd4, 1'b1, 1'b0);
        push(32'd11);
        push(32'd22);
        check1("pre_reset_in_fill", in_ready, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check1("midrst_in_ready", in_ready, 1'b0);
        check1("midrst_busy", busy, 1'b0);
        check1("midrst_out_valid", out_valid, 1'b0);
        check32("midrst_out_data", out_data, 32'd0);
        check1("midrst_overflow", overflow, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check32($sformatf("midrst_entry%0d", i), dut.mem_q[i], 32'd0);
        end
        @(negedge clk);
        check1("midrst_stays_idle", busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
